// File: rtl/slot_io_filter.sv
// Slot pad I/O block: 2-flop input sync, per-pin glitch filter, masked drive/direction registers.
// Define SLOT_IO_EDGE_CAPTURE_EN to add the sticky rise/fall flags on the filtered levels.
module slot_io_filter #(
    parameter int N_PINS = 22,
    parameter int FILT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PINS-1:0] slot_in,
    output logic [N_PINS-1:0] slot_out,
    output logic [N_PINS-1:0] slot_outen,
    input  logic              out_wr,
    input  logic [N_PINS-1:0] out_data,
    input  logic [N_PINS-1:0] out_mask,
    input  logic              dir_wr,
    input  logic [N_PINS-1:0] dir_data,
    input  logic [FILT_W-1:0] filt_len,
    output logic [N_PINS-1:0] pin_state,
    output logic [N_PINS-1:0] rise_flags,
    output logic [N_PINS-1:0] fall_flags,
    input  logic [N_PINS-1:0] flag_clr
);
    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};
    localparam logic [FILT_W-1:0] CNT_MAX  = {FILT_W{1'b1}};

    logic [N_PINS-1:0] r_s1;
    logic [N_PINS-1:0] r_s2;
    logic [N_PINS-1:0] r_pin_state;
    logic [N_PINS-1:0] r_slot_out;
    logic [N_PINS-1:0] r_slot_outen;
    logic [FILT_W-1:0] r_cnt [N_PINS];

    logic [FILT_W-1:0] w_cnt_nxt [N_PINS];
    logic [N_PINS-1:0] w_commit;
    logic [FILT_W-1:0] w_len_m1;
    logic              w_len_zero;

    assign w_len_m1   = filt_len - CNT_ONE;
    assign w_len_zero = (filt_len == CNT_ZERO);

    // Per-pin filter decision; >= lets a lowered filt_len commit on the very next edge
    always_comb begin
        w_commit = {N_PINS{1'b0}};
        for (int i = 0; i < N_PINS; i++) begin
            w_cnt_nxt[i] = CNT_ZERO;
            if (r_s2[i] == r_pin_state[i]) begin
                w_cnt_nxt[i] = CNT_ZERO;
            end else if (w_len_zero || (r_cnt[i] >= w_len_m1)) begin
                w_commit[i]  = 1'b1;
                w_cnt_nxt[i] = CNT_ZERO;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_cnt_nxt[i] = CNT_MAX;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    // Synchronizer, filter state and pad drive/direction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1         <= {N_PINS{1'b0}};
            r_s2         <= {N_PINS{1'b0}};
            r_pin_state  <= {N_PINS{1'b0}};
            r_slot_out   <= {N_PINS{1'b0}};
            r_slot_outen <= {N_PINS{1'b1}};
            for (int i = 0; i < N_PINS; i++) begin
                r_cnt[i] <= CNT_ZERO;
            end
        end else begin
            r_s1        <= slot_in;
            r_s2        <= r_s1;
            r_pin_state <= r_pin_state ^ w_commit;
            for (int i = 0; i < N_PINS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (out_wr) begin
                r_slot_out <= (r_slot_out & ~out_mask) | (out_data & out_mask);
            end
            if (dir_wr) begin
                r_slot_outen <= dir_data;
            end
        end
    end

    assign slot_out   = r_slot_out;
    assign slot_outen = r_slot_outen;
    assign pin_state  = r_pin_state;

`ifdef SLOT_IO_EDGE_CAPTURE_EN
    logic [N_PINS-1:0] r_pin_state_d;
    logic [N_PINS-1:0] r_rise;
    logic [N_PINS-1:0] r_fall;

    // Sticky edge flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pin_state_d <= {N_PINS{1'b0}};
            r_rise        <= {N_PINS{1'b0}};
            r_fall        <= {N_PINS{1'b0}};
        end else begin
            r_pin_state_d <= r_pin_state;
            r_rise        <= (r_rise & ~flag_clr) | (r_pin_state & ~r_pin_state_d);
            r_fall        <= (r_fall & ~flag_clr) | (~r_pin_state & r_pin_state_d);
        end
    end

    assign rise_flags = r_rise;
    assign fall_flags = r_fall;
`else
    logic w_unused_flag_clr;

    assign w_unused_flag_clr = ^flag_clr;
    assign rise_flags        = {N_PINS{1'b0}};
    assign fall_flags        = {N_PINS{1'b0}};
`endif

endmodule
